// File: rtl/wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO (write clock domain).
// Define ALMOST_FULL_EN to add the registered almost_full output and its occupancy logic.
module wptr_full #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst,
  input  logic          w_rq,
  input  logic [AW:0]   rptr_async,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr,
  output logic          wr_en,
  output logic          full,
`ifdef ALMOST_FULL_EN
  output logic          almost_full,
`endif
  output logic          overflow
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 1 || AF_THRESH > DEPTH) begin : g_param_check
    $error("wptr_full: DEPTH must be a power of two >= 4 and AF_THRESH <= DEPTH");
  end

  logic [AW:0] wbin;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] wq1;
  logic [AW:0] wq2;
  logic        full_next;

  assign wr_en      = w_rq & ~full;
  assign waddr      = wbin[AW-1:0];
  assign wbin_next  = wbin + (AW + 1)'(wr_en);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the next write pointer is exactly one lap ahead of the synchronized read pointer.
  assign full_next  = (wgray_next == {~wq2[AW:AW-1], wq2[AW-2:0]});

`ifdef ALMOST_FULL_EN
  localparam logic [AW:0] AF_LEVEL = (AW + 1)'(AF_THRESH);

  logic [AW:0] rbin_s;
  logic [AW:0] occupancy;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(wq2 >> i);
    end
  end

  assign occupancy = wbin_next - rbin_s;
`endif

  // The occupancy is pessimistic because wq2 lags the real read pointer by two edges.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      wbin        <= '0;
      wptr        <= '0;
      wq1         <= '0;
      wq2         <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
`ifdef ALMOST_FULL_EN
      almost_full <= 1'b0;
`endif
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      wq1         <= rptr_async;
      wq2         <= wq1;
      full        <= full_next;
      if (w_rq && full) begin
        overflow  <= 1'b1;
      end
`ifdef ALMOST_FULL_EN
      almost_full <= (occupancy >= AF_LEVEL);
`endif
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (DEPTH=16): directed scenarios plus random traffic checked against
// a count-based model of writes, synchronized reads, full and overflow.
module tb_wptr_full;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 14;

  logic          w_clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_rq = 1'b0;
  logic [AW:0]   rptr_async = '0;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wr_en;
  logic          full;
  logic          overflow;
`ifdef ALMOST_FULL_EN
  logic          almost_full;
`endif

  int   errors = 0;
  int   checks = 0;

  // Model: counts of words written and of reads as seen through the two-edge synchronizer.
  int   m_wcnt = 0;
  int   m_rq1 = 0;
  int   m_rq2 = 0;
  int   rcnt = 0;
  logic m_full = 1'b0;
  logic m_ovf = 1'b0;
  logic m_af = 1'b0;

  wptr_full #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .w_clk      (w_clk),
    .rst        (rst),
    .w_rq       (w_rq),
    .rptr_async (rptr_async),
    .waddr      (waddr),
    .wptr       (wptr),
    .wr_en      (wr_en),
    .full       (full),
`ifdef ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .overflow   (overflow)
  );

  always #5 w_clk = ~w_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic drive(input logic rst_v, input logic w_v, input int r_v);
    @(negedge w_clk);
    rst        = rst_v;
    w_rq       = w_v;
    rcnt       = r_v;
    rptr_async = to_gray(r_v);
    #1;
  endtask

  task automatic advance();
    logic old_full;
    @(posedge w_clk);
    if (rst) begin
      m_wcnt = 0;
      m_rq1  = 0;
      m_rq2  = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      m_af   = 1'b0;
    end else begin
      old_full = m_full;
      if (w_rq && !old_full) m_wcnt = m_wcnt + 1;
      if (w_rq && old_full) m_ovf = 1'b1;
      m_full = ((m_wcnt - m_rq2) == DEPTH);
      m_af   = ((m_wcnt - m_rq2) >= AF);
      m_rq2  = m_rq1;
      m_rq1  = rcnt;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 0);
    advance();
    drive(1'b1, 1'b1, 0);
    advance();
    checks++; if (wptr !== 5'b00000) begin errors++; $display("[TB] FAIL reset_wptr: got %b want %b", wptr, 5'b00000); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d want 0", waddr); end
`ifdef ALMOST_FULL_EN
    checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost_full: got %b want 0", almost_full); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 0);
      checks++; if (waddr !== AW'(i)) begin errors++; $display("[TB] FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
      checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL fill_wr_en[%0d]: got %b want 1", i, wr_en); end
      advance();
      checks++; if (full !== (i == DEPTH - 1)) begin errors++; $display("[TB] FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH - 1)); end
    end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("[TB] FAIL fill_wptr: got %b want %b", wptr, 5'b11000); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 0);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL ovf_wr_en[%0d]: got %b want 0", i, wr_en); end
      advance();
      checks++; if (wptr !== 5'b11000) begin errors++; $display("[TB] FAIL ovf_wptr[%0d]: got %b want %b", i, wptr, 5'b11000); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag[%0d]: got %b want 1", i, overflow); end
    end
    drive(1'b0, 1'b0, 0);
    advance();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_release();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1);
      advance();
      checks++; if (full !== (k < 2)) begin errors++; $display("[TB] FAIL release_full[edge %0d]: got %b want %b", k + 1, full, (k < 2)); end
    end
    drive(1'b0, 1'b1, 1);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL release_wr_en: got %b want 1", wr_en); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("[TB] FAIL release_waddr: got %0d want 0", waddr); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 0);
    advance();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_ovf_clear: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 0);
      advance();
    end
    checks++; if (wptr !== to_gray(8)) begin errors++; $display("[TB] FAIL mid_wptr_before: got %b want %b", wptr, to_gray(8)); end
    drive(1'b1, 1'b1, 0);
    advance();
    checks++; if (wptr !== 5'b00000) begin errors++; $display("[TB] FAIL mid_wptr: got %b want 0", wptr); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL mid_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %b want 0", overflow); end
    drive(1'b0, 1'b1, 0);
    checks++; if (waddr !== 4'd0) begin errors++; $display("[TB] FAIL mid_waddr: got %0d want 0", waddr); end
    advance();
    checks++; if (wptr !== 5'b00001) begin errors++; $display("[TB] FAIL mid_wptr_after: got %b want 00001", wptr); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 0);
    advance();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      drive(1'b0, 1'b1, (i >= 4) ? i - 4 : 0);
      checks++; if (waddr !== AW'(i % DEPTH)) begin errors++; $display("[TB] FAIL wrap_waddr[%0d]: got %0d want %0d", i, waddr, i % DEPTH); end
      advance();
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_full[%0d]: got %b want 0", i, full); end
      if (i == 2 * DEPTH - 2) begin
        checks++; if (wptr !== 5'b10000) begin errors++; $display("[TB] FAIL wrap_wptr31: got %b want 10000", wptr); end
      end
      if (i == 2 * DEPTH - 1) begin
        checks++; if (wptr !== 5'b00000) begin errors++; $display("[TB] FAIL wrap_wptr0: got %b want 00000", wptr); end
      end
    end
  endtask

  task automatic test_random();
    int  r;
    logic w;
    drive(1'b1, 1'b0, 0);
    advance();
    r = 0;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 40 && r < m_wcnt) r = r + 1;
      drive(1'b0, w, r);
      checks++; if (wr_en !== (w && !m_full)) begin errors++; $display("[TB] FAIL rand_wr_en[%0d]: got %b want %b", i, wr_en, (w && !m_full)); end
      checks++; if (waddr !== AW'(m_wcnt % DEPTH)) begin errors++; $display("[TB] FAIL rand_waddr[%0d]: got %0d want %0d", i, waddr, m_wcnt % DEPTH); end
      advance();
      checks++; if (wptr !== to_gray(m_wcnt)) begin errors++; $display("[TB] FAIL rand_wptr[%0d]: got %b want %b", i, wptr, to_gray(m_wcnt)); end
      checks++; if (full !== m_full) begin errors++; $display("[TB] FAIL rand_full[%0d]: got %b want %b", i, full, m_full); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow[%0d]: got %b want %b", i, overflow, m_ovf); end
`ifdef ALMOST_FULL_EN
      checks++; if (almost_full !== m_af) begin errors++; $display("[TB] FAIL rand_almost_full[%0d]: got %b want %b", i, almost_full, m_af); end
`endif
    end
  endtask

`ifdef ALMOST_FULL_EN
  task automatic test_almost_full();
    drive(1'b1, 1'b0, 0);
    advance();
    for (int i = 0; i < AF; i++) begin
      drive(1'b0, 1'b1, 0);
      advance();
      checks++; if (almost_full !== (i == AF - 1)) begin errors++; $display("[TB] FAIL af_rise[%0d]: got %b want %b", i, almost_full, (i == AF - 1)); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1);
      advance();
      checks++; if (almost_full !== (k < 2)) begin errors++; $display("[TB] FAIL af_fall[edge %0d]: got %b want %b", k + 1, almost_full, (k < 2)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_reset_mid();
    test_wrap();
`ifdef ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
